sm_feeder_mc: RTL and testbench

- Multi-channel successor to the two-toggle scoring-module feeder.
- Accepts one packed target word (ID, length, 2-bit bases) per load and holds it in a one-deep staging register.
- Dispatches each target round-robin to one of CHANNELS scoring-module slots, then serialises its bases one per cycle with that slot's enable.
- Keeps a per-channel ID FIFO so that each result valid pops the matching sequence ID in order.

---
 rtl/sm_feeder_mc.sv | 256 +++++++++++++++++++++++++
 tb/tb_sm_feeder_mc.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_feeder_mc.sv
// sm_feeder_mc
//
// Multi-channel scoring-module feeder. A packed target word (ID, length,
// 2-bit bases) is loaded into a one-deep staging register, dispatched
// round-robin to one of CHANNELS scoring slots, and then serialised one base
// per cycle together with that slot's enable. Each channel keeps a small
// FIFO of dispatched sequence IDs so that every result-valid pulse from a
// slot can be paired, in order, with the ID of the target that produced it.
//
// Ports
//   clk       rising-edge clock for all logic
//   rst       synchronous, active-low reset
//   ld        load request, accepted when ld & ~full
//   feed_in   packed target {ID, length, bases}; base i at [2i+1:2i]
//   slot_rdy  per-channel "slot can take a new target"
//   re        per-channel result valid, pops that channel's ID FIFO
//   en        one-hot base-valid, one bit per channel
//   data_out  current base (holds its value while en is 0)
//   last      high together with the final base of a target
//   full      staging register occupied
//   id_out    show-ahead head of each ID FIFO, channel c at [c*ID_WIDTH+:ID_WIDTH]
//   id_vld    per-channel ID FIFO non-empty
//   err       sticky per-channel "result valid arrived with an empty FIFO"

module sm_feeder_mc #(
  parameter int TARGET_LENGTH = 128,
  parameter int LEN_WIDTH     = 12,
  parameter int ID_WIDTH      = 48,
  parameter int CHANNELS      = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          ld,
  input  logic [ID_WIDTH+LEN_WIDTH+2*TARGET_LENGTH-1:0] feed_in,
  input  logic [CHANNELS-1:0]                           slot_rdy,
  input  logic [CHANNELS-1:0]                           re,
  output logic [CHANNELS-1:0]                           en,
  output logic [1:0]                                    data_out,
  output logic                                          last,
  output logic                                          full,
  output logic [CHANNELS*ID_WIDTH-1:0]                  id_out,
  output logic [CHANNELS-1:0]                           id_vld,
  output logic [CHANNELS-1:0]                           err
);

  localparam int BASE_W = 2 * TARGET_LENGTH;
  localparam int WORD_W = ID_WIDTH + LEN_WIDTH + BASE_W;
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // Staging register
  logic [WORD_W-1:0]    stg_q;
  logic                 full_q;
  logic [ID_WIDTH-1:0]  stg_id;
  logic [LEN_WIDTH-1:0] stg_len;
  logic [LEN_WIDTH-1:0] stg_len_c;
  logic [BASE_W-1:0]    stg_bases;

  // Serializer
  state_t               state_q;
  state_t               state_d;
  logic [BASE_W-1:0]    shift_q;
  logic [LEN_WIDTH-1:0] rem_q;
  logic [CH_W-1:0]      ch_q;
  logic [CH_W-1:0]      rr_q;

  // Dispatch decision
  logic [CHANNELS-1:0]  elig;
  logic                 pick_found;
  logic [CH_W-1:0]      pick_ch;
  logic                 slot_free;
  logic                 go;
  logic                 dispatch;

  // Per-channel ID FIFOs
  logic [ID_WIDTH-1:0]  mem_q [CHANNELS][FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_q  [CHANNELS];
  logic [PTR_W-1:0]     rd_q  [CHANNELS];
  logic [CNT_W-1:0]     cnt_q [CHANNELS];
  logic [CHANNELS-1:0]  err_q;
  logic [CHANNELS-1:0]  push;
  logic [CHANNELS-1:0]  pop;

  // Field extraction and length clamp. Lengths above TARGET_LENGTH are
  // treated as a full-length target.
  always_comb begin
    stg_id    = stg_q[WORD_W-1 -: ID_WIDTH];
    stg_len   = stg_q[BASE_W +: LEN_WIDTH];
    stg_bases = stg_q[BASE_W-1:0];
    stg_len_c = (stg_len > LEN_WIDTH'(TARGET_LENGTH)) ? LEN_WIDTH'(TARGET_LENGTH) : stg_len;
  end

  // A channel is eligible when its slot is ready and its ID FIFO has room.
  // Pops on the same edge are deliberately not counted as freeing space.
  // The winner is the first eligible channel at or after the RR pointer.
  always_comb begin
    int unsigned idx;
    elig       = '0;
    pick_found = 1'b0;
    pick_ch    = '0;
    idx        = 0;
    for (int c = 0; c < CHANNELS; c++) begin
      elig[c] = slot_rdy[c] && (cnt_q[c] < CNT_W'(FIFO_DEPTH));
    end
    for (int i = 0; i < CHANNELS; i++) begin
      idx = (int'(rr_q) + i) % CHANNELS;
      if (!pick_found && elig[CH_W'(idx)]) begin
        pick_found = 1'b1;
        pick_ch    = CH_W'(idx);
      end
    end
  end

  // The serializer can accept a new target while idle, or on the edge that
  // retires the final base of the current one, which gives zero-bubble
  // back-to-back streaming. A zero-length target consumes the dispatch slot
  // but produces no beats and no ID push.
  always_comb begin
    slot_free = (state_q == IDLE) || ((state_q == STREAM) && (rem_q == LEN_WIDTH'(1)));
    go        = full_q && slot_free && pick_found;
    dispatch  = go && (stg_len_c != '0);
  end

  // Next-state logic and serializer outputs
  always_comb begin
    state_d  = state_q;
    en       = '0;
    last     = 1'b0;
    data_out = shift_q[1:0];
    case (state_q)
      IDLE: begin
        if (dispatch) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        en[ch_q] = 1'b1;
        if (rem_q == LEN_WIDTH'(1)) begin
          last    = 1'b1;
          state_d = dispatch ? STREAM : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Staging, serializer datapath and RR pointer. The shift register is left
  // untouched when a stream ends without a follow-on dispatch, so data_out
  // keeps showing the final base while en is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stg_q   <= '0;
      full_q  <= 1'b0;
      state_q <= IDLE;
      shift_q <= '0;
      rem_q   <= '0;
      ch_q    <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;

      if (ld && !full_q) begin
        stg_q  <= feed_in;
        full_q <= 1'b1;
      end else if (go) begin
        full_q <= 1'b0;
      end

      if (dispatch) begin
        shift_q <= stg_bases;
        rem_q   <= stg_len_c;
        ch_q    <= pick_ch;
        rr_q    <= (pick_ch == CH_W'(CHANNELS - 1)) ? '0 : pick_ch + 1'b1;
      end else if (state_q == STREAM) begin
        if (rem_q != LEN_WIDTH'(1)) begin
          shift_q <= shift_q >> 2;
        end
        rem_q <= rem_q - 1'b1;
      end
    end
  end

  // FIFO push/pop strobes. A pop on an empty FIFO is refused and flagged.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      push[c] = dispatch && (pick_ch == CH_W'(c));
      pop[c]  = re[c] && (cnt_q[c] != '0);
    end
  end

  // FIFO storage needs no reset; only the pointers and counts define content.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (push[c]) begin
        mem_q[c][wr_q[c]] <= stg_id;
      end
    end
  end

  // FIFO pointers, occupancy and sticky error flags. Pointers wrap naturally
  // because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_q[c]  <= '0;
        rd_q[c]  <= '0;
        cnt_q[c] <= '0;
      end
      err_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (push[c]) begin
          wr_q[c] <= wr_q[c] + 1'b1;
        end
        if (pop[c]) begin
          rd_q[c] <= rd_q[c] + 1'b1;
        end
        if (push[c] && !pop[c]) begin
          cnt_q[c] <= cnt_q[c] + 1'b1;
        end else if (pop[c] && !push[c]) begin
          cnt_q[c] <= cnt_q[c] - 1'b1;
        end
        if (re[c] && (cnt_q[c] == '0)) begin
          err_q[c] <= 1'b1;
        end
      end
    end
  end

  // Show-ahead ID outputs; an empty FIFO presents zero rather than stale data.
  always_comb begin
    id_out = '0;
    id_vld = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      id_vld[c] = (cnt_q[c] != '0);
      if (cnt_q[c] != '0) begin
        id_out[c*ID_WIDTH +: ID_WIDTH] = mem_q[c][rd_q[c]];
      end
    end
  end

  assign full = full_q;
  assign err  = err_q;

endmodule

// File: tb/tb_sm_feeder_mc.sv
// tb_sm_feeder_mc
//
// Self-checking bench for sm_feeder_mc. A behavioural model keeps the staged
// target, a queue of pending output beats and a list of outstanding IDs tagged
// by channel; every cycle the DUT outputs are compared against it. Directed
// scenarios are followed by a long randomized run.

module tb_sm_feeder_mc;

  localparam int TL = 128;
  localparam int LW = 12;
  localparam int IW = 48;
  localparam int CH = 3;
  localparam int FD = 2;
  localparam int WW = IW + LW + 2 * TL;

  logic              clk;
  logic              rst;
  logic              ld;
  logic [WW-1:0]     feed_in;
  logic [CH-1:0]     slot_rdy;
  logic [CH-1:0]     re;
  logic [CH-1:0]     en;
  logic [1:0]        data_out;
  logic              last;
  logic              full;
  logic [CH*IW-1:0]  id_out;
  logic [CH-1:0]     id_vld;
  logic [CH-1:0]     err;

  sm_feeder_mc #(
    .TARGET_LENGTH(TL),
    .LEN_WIDTH    (LW),
    .ID_WIDTH     (IW),
    .CHANNELS     (CH),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .feed_in  (feed_in),
    .slot_rdy (slot_rdy),
    .re       (re),
    .en       (en),
    .data_out (data_out),
    .last     (last),
    .full     (full),
    .id_out   (id_out),
    .id_vld   (id_vld),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    int         ch;
    logic [1:0] base;
    bit         last;
  } beat_t;

  typedef struct {
    int          ch;
    logic [IW-1:0] id;
  } ent_t;

  beat_t          beats[$];
  ent_t           ids[$];
  bit             m_full;
  logic [WW-1:0]  m_word;
  int             m_rr;
  logic [CH-1:0]  m_err;
  logic [1:0]     m_last_data;

  int n_cmp;
  int n_err;
  int cyc;

  function automatic int cnt_of(input int c);
    int n = 0;
    foreach (ids[i]) if (ids[i].ch == c) n++;
    return n;
  endfunction

  function automatic logic [IW-1:0] head_of(input int c);
    foreach (ids[i]) if (ids[i].ch == c) return ids[i].id;
    return '0;
  endfunction

  function automatic void pop_of(input int c);
    for (int i = 0; i < ids.size(); i++) begin
      if (ids[i].ch == c) begin
        ids.delete(i);
        return;
      end
    end
  endfunction

  function automatic logic [WW-1:0] mk(input logic [IW-1:0] id, input int len,
                                       input logic [2*TL-1:0] b);
    return {id, LW'(len), b};
  endfunction

  function automatic logic [2*TL-1:0] rand_bases();
    logic [2*TL-1:0] b;
    for (int i = 0; i < (2 * TL) / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // One clock edge of the reference model, using the inputs applied before it
  task automatic model_step(input bit r, input bit ld_i, input logic [WW-1:0] f,
                            input logic [CH-1:0] sr, input logic [CH-1:0] re_i);
    int  pc[CH];
    bit  pre_full;
    int  pre_beats;
    int  len;
    int  c;
    bit  found;
    if (!r) begin
      beats.delete();
      ids.delete();
      m_full      = 0;
      m_word      = '0;
      m_rr        = 0;
      m_err       = '0;
      m_last_data = '0;
      return;
    end
    pre_full  = m_full;
    pre_beats = beats.size();
    for (int k = 0; k < CH; k++) pc[k] = cnt_of(k);

    for (int k = 0; k < CH; k++) begin
      if (re_i[k]) begin
        if (pc[k] > 0) pop_of(k);
        else m_err[k] = 1'b1;
      end
    end

    if (pre_beats > 0) begin
      m_last_data = beats[0].base;
      void'(beats.pop_front());
    end

    if (pre_full && pre_beats <= 1) begin
      found = 0;
      c = 0;
      for (int i = 0; i < CH; i++) begin
        int k = (m_rr + i) % CH;
        if (!found && sr[k] && pc[k] < FD) begin
          found = 1;
          c = k;
        end
      end
      if (found) begin
        len = int'(m_word[2*TL +: LW]);
        if (len > TL) len = TL;
        m_full = 0;
        if (len > 0) begin
          ent_t e;
          e.ch = c;
          e.id = m_word[WW-1 -: IW];
          ids.push_back(e);
          m_rr = (c + 1) % CH;
          for (int i = 0; i < len; i++) begin
            beat_t bt;
            bt.ch   = c;
            bt.base = m_word[2*i +: 2];
            bt.last = (i == len - 1);
            beats.push_back(bt);
          end
        end
      end
    end

    if (ld_i && !pre_full) begin
      m_full = 1;
      m_word = f;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic compare_all();
    logic [CH-1:0] e_en;
    logic [CH-1:0] e_vld;
    e_en  = '0;
    e_vld = '0;
    if (beats.size() > 0) e_en[beats[0].ch] = 1'b1;
    for (int k = 0; k < CH; k++) e_vld[k] = (cnt_of(k) > 0);
    checkOutput("en", 64'(en), 64'(e_en));
    checkOutput("data_out", 64'(data_out),
                64'((beats.size() > 0) ? beats[0].base : m_last_data));
    checkOutput("last", 64'(last), 64'((beats.size() > 0) ? beats[0].last : 1'b0));
    checkOutput("full", 64'(full), 64'(m_full));
    checkOutput("id_vld", 64'(id_vld), 64'(e_vld));
    checkOutput("err", 64'(err), 64'(m_err));
    for (int k = 0; k < CH; k++) begin
      checkOutput($sformatf("id_out%0d", k), 64'(id_out[k*IW +: IW]), 64'(head_of(k)));
    end
  endtask

  task automatic applyStimulus(input bit r, input bit ld_i, input logic [WW-1:0] f,
                               input logic [CH-1:0] sr, input logic [CH-1:0] re_i);
    rst      = r;
    ld       = ld_i;
    feed_in  = f;
    slot_rdy = sr;
    re       = re_i;
    @(posedge clk);
    model_step(r, ld_i, f, sr, re_i);
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input logic [CH-1:0] sr);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, '0, sr, '0);
  endtask

  // Pop every non-empty FIFO until all are empty (bounded)
  task automatic drain();
    for (int i = 0; i < 2 * FD + 2; i++) begin
      logic [CH-1:0] r_v;
      r_v = '0;
      for (int k = 0; k < CH; k++) r_v[k] = (cnt_of(k) > 0);
      applyStimulus(1, 0, '0, '1, r_v);
    end
  endtask

  initial begin
    logic [2*TL-1:0] b;
    int              k;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    rst = 1'b0; ld = 1'b0; feed_in = '0; slot_rdy = '0; re = '0;

    // Reset and a single five-base target
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, '0, '0);
    b = '0;
    b[1:0] = 2'b10; b[3:2] = 2'b11; b[5:4] = 2'b00; b[7:6] = 2'b01; b[9:8] = 2'b10;
    applyStimulus(1, 1, mk(48'd7, 5, b), '1, '0);
    idle(8, '1);
    checkOutput("t1_id0", 64'(id_out[IW-1:0]), 64'd7);
    drain();

    // Round robin, back-to-back loads of length 3
    k = 0;
    for (int i = 0; i < 60 && k < 6; i++) begin
      bit acc;
      acc = !m_full;
      applyStimulus(1, 1, mk(IW'(k), 3, rand_bases()), '1, '0);
      if (acc) k++;
    end
    checkOutput("rr_loads", 64'(k), 64'd6);
    idle(20, '1);
    drain();

    // Backpressure: second load is ignored while the first waits
    applyStimulus(1, 1, mk(48'hA1, 4, rand_bases()), '0, '0);
    applyStimulus(1, 1, mk(48'hB2, 4, rand_bases()), '0, '0);
    applyStimulus(1, 1, mk(48'hB2, 4, rand_bases()), '0, '0);
    checkOutput("bp_full", 64'(full), 64'd1);
    applyStimulus(1, 0, '0, 3'b010, '0);
    idle(8, '0);
    checkOutput("bp_id1", 64'(id_out[IW +: IW]), 64'hA1);
    drain();

    // FIFO full on a single ready channel
    for (int i = 0; i < 30; i++) applyStimulus(1, 1, mk(IW'(100 + i), 2, rand_bases()), 3'b001, '0);
    applyStimulus(1, 0, '0, 3'b001, 3'b001);
    idle(6, 3'b001);
    drain();
    idle(4, '1);

    // Zero length and over-long targets
    applyStimulus(1, 1, mk(48'h55, 0, rand_bases()), '1, '0);
    idle(4, '1);
    checkOutput("len0_full", 64'(full), 64'd0);
    applyStimulus(1, 1, mk(48'h66, 200, rand_bases()), '1, '0);
    idle(TL + 6, '1);
    drain();

    // Result valid with an empty FIFO sets a sticky error
    applyStimulus(1, 0, '0, '1, 3'b010);
    idle(3, '1);
    checkOutput("err1_sticky", 64'(err[1]), 64'd1);

    // Reset in the middle of a stream
    applyStimulus(1, 1, mk(48'h77, 10, rand_bases()), '1, '0);
    idle(4, '1);
    applyStimulus(0, 0, '0, '1, '0);
    checkOutput("rst_mid_en", 64'(en), 64'd0);
    idle(3, '1);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      int            sel;
      int            len;
      logic [CH-1:0] r_v;
      sel = int'($urandom_range(0, 15));
      if (sel == 0) len = 0;
      else if (sel == 1) len = TL + int'($urandom_range(0, 100));
      else len = int'($urandom_range(1, 12));
      for (int c = 0; c < CH; c++) r_v[c] = ($urandom_range(0, 5) == 0);
      applyStimulus(($urandom_range(0, 499) != 0), ($urandom_range(0, 2) != 0),
                    mk({$urandom, 16'($urandom)}, len, rand_bases()),
                    CH'($urandom), r_v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
